// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a word-addressed data memory with registered read data.
// Handles sub-word loads with extension, read-modify-write for sub-word stores, and fault rejection.
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid
// RD    | read strobe to memory for the latched word index
// CAP   | memory data valid; extract/extend a load or merge a sub-word store
// WR    | write strobe with the full word
// RESP  | one-cycle response to writeback
module mem_access_unit #(
   parameter int MEM_WORDS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RESP
   } state_t;

   localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        we_q, we_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

   logic        req_fault;

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      unique case (off)
         2'd0: b = word[7:0];
         2'd1: b = word[15:8];
         2'd2: b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      unique case (size)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
      logic [31:0] r;
      r = old;
      unique case (size)
         2'b00: begin
            unique case (off)
               2'd0: r[7:0]   = wd[7:0];
               2'd1: r[15:8]  = wd[7:0];
               2'd2: r[23:16] = wd[7:0];
               default: r[31:24] = wd[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) r[31:16] = wd[15:0];
            else        r[15:0]  = wd[15:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   // Alignment and range are judged on the raw request so a fault never strobes memory.
   always_comb begin
      req_fault = 1'b0;
      unique case (req_size)
         2'b01:   req_fault = req_addr[0];
         2'b10:   req_fault = (req_addr[1:0] != 2'b00);
         2'b11:   req_fault = 1'b1;
         default: req_fault = 1'b0;
      endcase
      if (req_addr[31:2] >= WORD_LIMIT) req_fault = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         we_q    <= we_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      we_d       = we_q;
      uns_d      = uns_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      fault_d    = fault_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_fault = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_wdata  = '0;
      mem_addr   = (state_q == S_IDLE) ? '0 : {2'b00, addr_q[31:2]};

      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d  = req_addr;
               size_d  = req_size;
               we_d    = req_we;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               rdata_d = '0;
               fault_d = req_fault;
               if (req_fault)                          state_d = S_RESP;
               else if (req_we && req_size == 2'b10)   state_d = S_WR;
               else                                    state_d = S_RD;
            end
         end
         S_RD: begin
            mem_read = 1'b1;
            state_d  = S_CAP;
         end
         S_CAP: begin
            if (we_q) begin
               wdata_d = store_merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
               state_d = S_WR;
            end else begin
               rdata_d = load_extend(mem_rdata, size_q, addr_q[1:0], uns_q);
               state_d = S_RESP;
            end
         end
         S_WR: begin
            mem_write = 1'b1;
            mem_wdata = wdata_q;
            state_d   = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_fault = fault_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Reset is synchronous, so outputs are gated here to keep a reset cycle inert.
      if (reset) begin
         req_ready  = 1'b0;
         resp_valid = 1'b0;
         resp_rdata = '0;
         resp_fault = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_wdata  = '0;
         mem_addr   = '0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random requests against a byte-level memory model.
module tb_mem_access_unit;
   localparam int MEM_WORDS = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
   );

   // memory driven by the DUT strobes, plus the reference image the model updates
   logic [31:0] mem [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];
   logic [31:0] mem_rdata_r = '0;
   logic        preload = 1'b0;
   int          wr_edges = 0;
   int          resp_edges = 0;
   assign mem_rdata = mem_rdata_r;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_mem[i];
      end else begin
         if (mem_write) mem[mem_addr[2:0]] <= mem_wdata;
         if (mem_read)  mem_rdata_r <= mem[mem_addr[2:0]];
      end
      if (mem_write)  wr_edges <= wr_edges + 1;
      if (resp_valid) resp_edges <= resp_edges + 1;
   end

   int total = 0;
   int bad = 0;
   logic [31:0] last_rdata;
   logic        last_fault;
   logic [31:0] last_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: byte-array view of the addressed word, plain arithmetic for extension.
   task automatic ref_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic f, output logic [31:0] rd, output logic [31:0] neww,
                             output int lat, output int nr, output int nw);
      longint idx, off, v, w;
      longint bytes [4];
      idx = longint'(addr) / 4;
      off = longint'(addr) % 4;
      f = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && off != 0) || (idx >= MEM_WORDS);
      rd = '0; neww = '0; lat = 1; nr = 0; nw = 0;
      if (f) return;
      w = longint'(ref_mem[idx]);
      for (int k = 0; k < 4; k++) bytes[k] = (w >> (8 * k)) % 256;
      if (!we) begin
         nr = 1; lat = 3;
         if (size == 2'd0) begin
            v = bytes[off];
            if (!uns && v >= 128) v = v - 256;
         end else if (size == 2'd1) begin
            v = bytes[off] + 256 * bytes[off + 1];
            if (!uns && v >= 32768) v = v - 65536;
         end else v = w;
         rd = v[31:0];
      end else begin
         nw = 1;
         if (size == 2'd2) begin
            lat = 2;
            neww = wd;
         end else begin
            nr = 1; lat = 4;
            bytes[off] = longint'(wd) % 256;
            if (size == 2'd1) bytes[off + 1] = (longint'(wd) >> 8) % 256;
            v = bytes[0] + 256 * bytes[1] + 65536 * bytes[2] + 16777216 * bytes[3];
            neww = v[31:0];
         end
         ref_mem[idx] = neww;
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
      logic        ef;
      logic [31:0] erd, ew, idx;
      int          elat, enr, enw, nr, nw, nresp, rcyc;
      ref_access(we, size, uns, addr, wd, ef, erd, ew, elat, enr, enw);
      idx = addr >> 2;
      nr = 0; nw = 0; nresp = 0; rcyc = -1;
      @(negedge clk);
      check("ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'd0);
         if (mem_read) begin
            nr++;
            check("rd_addr", mem_addr, idx);
         end
         if (mem_write) begin
            nw++;
            last_wdata = mem_wdata;
            check("wr_addr", mem_addr, idx);
            check("wr_data", mem_wdata, ew);
         end
         if (resp_valid) begin
            nresp++;
            rcyc = c;
            last_rdata = resp_rdata;
            last_fault = resp_fault;
            check("resp_rdata", resp_rdata, erd);
            check("resp_fault", {31'b0, resp_fault}, {31'b0, ef});
         end
      end
      check("n_read", nr, enr);
      check("n_write", nw, enw);
      check("n_resp", nresp, 32'd1);
      check("latency", rcyc, elat);
      check("ready_after", {31'b0, req_ready}, 32'd1);
      if (!ef) check("mem_word", mem[idx[2:0]], ref_mem[idx[2:0]]);
   endtask

   initial begin
      logic        r_we, r_uns, f0;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wd, rd0, nw0;
      int          lat0, nr0, nw_0, acc [2], rsp [2], n_acc, n_rsp, n_rd, n_wr, wr0, rs0;

      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
      ref_mem[1] = 32'h8899AABB;
      preload = 1'b1;
      req_valid = 1'b1;
      @(negedge clk);
      check("rst_ready", {31'b0, req_ready}, 32'd0);
      check("rst_resp", {31'b0, resp_valid}, 32'd0);
      check("rst_write", {31'b0, mem_write}, 32'd0);
      @(posedge clk);
      #1;
      preload = 1'b0; reset = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'b0, req_ready}, 32'd1);
      check("idle_addr", mem_addr, 32'd0);
      check("idle_read", {31'b0, mem_read}, 32'd0);

      do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
      check("lw4", last_rdata, 32'h8899AABB);
      do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0);
      check("lb7", last_rdata, 32'hFFFFFF88);
      do_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0);
      check("lbu7", last_rdata, 32'h00000088);
      do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0);
      check("lh4", last_rdata, 32'hFFFFAABB);
      do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0);
      check("lhu6", last_rdata, 32'h00008899);
      do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h123456CC);
      check("sb5_wdata", last_wdata, 32'h8899CCBB);
      do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
      check("lw4_after_sb", last_rdata, 32'h8899CCBB);

      do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
      check("f_lh3", {31'b0, last_fault}, 32'd1);
      do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'h55);
      check("f_sw2", {31'b0, last_fault}, 32'd1);
      do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
      check("f_size3", {31'b0, last_fault}, 32'd1);
      do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      check("f_range", {31'b0, last_fault}, 32'd1);
      check("f_range_rdata", last_rdata, 32'd0);

      // reset raised while the sub-word store sits in its write cycle
      @(negedge clk);
      wr0 = wr_edges; rs0 = resp_edges;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
      req_addr = 32'h6; req_wdata = 32'h0000BEEF;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_wr_gated", {31'b0, mem_write}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_ready_after", {31'b0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      check("rst_no_write", wr_edges - wr0, 32'd0);
      check("rst_no_resp", resp_edges - rs0, 32'd0);
      check("rst_word1", mem[1], 32'h8899CCBB);

      // back-to-back with req_valid held high
      ref_access(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, f0, rd0, nw0, lat0, nr0, nw_0);
      ref_access(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, f0, rd0, nw0, lat0, nr0, nw_0);
      n_acc = 0; n_rsp = 0; n_rd = 0; n_wr = 0;
      acc[0] = -1; acc[1] = -1; rsp[0] = -1; rsp[1] = -1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h4; req_wdata = 32'h0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (n_acc == 1) begin
            req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
         end else if (n_acc == 2) req_valid = 1'b0;
         if (mem_read) n_rd++;
         if (mem_write) n_wr++;
         if (resp_valid) begin
            if (n_rsp < 2) rsp[n_rsp] = c;
            if (n_rsp == 0) check("b2b_lw", resp_rdata, 32'h8899CCBB);
            n_rsp++;
         end
         if (req_valid && req_ready) begin
            if (n_acc < 2) acc[n_acc] = c;
            n_acc++;
         end
      end
      req_valid = 1'b0;
      check("b2b_accepts", n_acc, 32'd2);
      check("b2b_resps", n_rsp, 32'd2);
      check("b2b_second_acc", acc[1], acc[0] + 4);
      check("b2b_gap", rsp[1] - rsp[0], 32'd3);
      check("b2b_reads", n_rd, 32'd1);
      check("b2b_writes", n_wr, 32'd1);
      check("b2b_word2", mem[2], 32'hDEADBEEF);

      for (int t = 0; t < 150; t++) begin
         r_we   = 1'($urandom);
         r_size = 2'($urandom_range(0, 3));
         r_uns  = 1'($urandom);
         r_wd   = $urandom;
         if ($urandom_range(0, 9) == 0) r_addr = $urandom;
         else r_addr = 32'($urandom_range(0, 39));
         if ($urandom_range(0, 2) != 0) begin
            if (r_size == 2'd1) r_addr[0] = 1'b0;
            if (r_size == 2'd2) r_addr[1:0] = 2'b00;
         end
         do_req(r_we, r_size, r_uns, r_addr, r_wd);
      end

      for (int i = 0; i < MEM_WORDS; i++) check("final_mem", mem[i], ref_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
